koa_seq_ctrl: RTL and testbench
===============================

KOA_SEQ_CTRL -- requirements
Module: koa_seq_ctrl

Interface
REQ-001 SHALL have parameter SW, default 54, operand width in bits; only even SW ≥ 8 is legal.
REQ-002 SHALL have localparam H = SW/2, the half-operand width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid_i  input  1  operand pair offered.
REQ-006 SHALL have port in_ready_o  output  1  block can accept an operand pair.
REQ-007 SHALL have port Data_A_i  input  SW  multiplicand, unsigned.
REQ-008 SHALL have port Data_B_i  input  SW  multiplier, unsigned.
REQ-009 SHALL have port out_valid_o  output  1  product available.
REQ-010 SHALL have port out_ready_i  input  1  consumer takes the product.
REQ-011 SHALL have port sgf_result_o  output  2*SW  unsigned product A*B.
REQ-012 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-013 SHALL sequence one shared (H+1)x(H+1) product unit over the three Karatsuba partial products, one product per cycle.
REQ-014 SHALL implement FSM states IDLE, MUL_L, MUL_R, MUL_M, COMB and DONE.
REQ-015 SHALL assert in_ready_o only in IDLE; an accept occurs on an edge where in_valid_i && in_ready_o.
REQ-016 SHALL, on accept, register A and B, register sumA = A_hi + A_lo and sumB = B_hi + B_lo (each H+1 bits, carry kept), and go to MUL_L.
REQ-017 SHALL, in MUL_L, feed {0,A_hi} x {0,B_hi} to the unit, register Q_L (2H bits) and go to MUL_R.
REQ-018 SHALL, in MUL_R, feed {0,A_lo} x {0,B_lo}, register Q_R (2H bits) and go to MUL_M.
REQ-019 SHALL, in MUL_M, feed sumA x sumB, register Q_M (2H+2 bits) and go to COMB.
REQ-020 SHALL, in COMB, register result = {Q_L,Q_R} + ((Q_M - Q_L - Q_R) << H), computed at 2*SW+1 bits and truncated to 2*SW bits, then go to DONE.
REQ-021 SHALL treat the middle term Q_M - Q_L - Q_R as never negative; no sign handling is required.
REQ-022 SHALL assert out_valid_o only in DONE, rising exactly 4 edges after the accepting edge; latency is 5 cycles and minimum issue interval is 6 cycles.
REQ-023 SHALL hold sgf_result_o stable while out_valid_o && !out_ready_i, for any stall length.
REQ-024 SHALL, on an edge in DONE with out_ready_i high, go to IDLE with out_valid_o low; sgf_result_o retains its value until the next COMB.
REQ-025 SHALL ignore in_valid_i and operand changes while busy; the captured operands are unaffected.
REQ-026 SHALL ignore out_ready_i outside DONE.
REQ-027 SHALL drive a fully registered sgf_result_o; there is no combinational path from inputs to outputs except through the FSM state.

Reset
REQ-028 SHALL, when rst is high at an edge in any state including mid-operation, force state IDLE, out_valid_o=0, sgf_result_o=0, busy_o=0, in_ready_o=1 and all partial registers to 0.
REQ-029 SHALL discard any in-flight operation on reset; rst has priority over an accept on the same edge.

Structure
REQ-030 SHALL place state encodings, H and partial-product widths in shared package koa_seq_pkg.
REQ-031 SHALL contain one sub-module, koa_seq_core, a combinational (H+1)-bit unsigned multiplier; the FSM, muxes and combine adder stay in koa_seq_ctrl.

Verification
REQ-032 SHALL test: A=3, B=5 accepted at edge t -> out_valid_o high after edge t+4, sgf_result_o=15.
REQ-033 SHALL test: A=B=2^54-1 -> sgf_result_o = 2^108 - 2^55 + 1 (both sum carries set).
REQ-034 SHALL test: A=2^27, B=2^27 -> 2^54; A=2^27-1, B=2^27+1 -> 2^54-1 (mixed halves).
REQ-035 SHALL test: out_ready_i held low 3 cycles in DONE -> result stable, in_ready_o=0, state exits DONE on the first edge with out_ready_i high.
REQ-036 SHALL test: new operands with in_valid_i=1 during MUL_R -> ignored; the first product is correct.
REQ-037 SHALL test: rst pulsed during MUL_M -> next cycle in_ready_o=1, out_valid_o=0, sgf_result_o=0; the next operation completes correctly.

Source files
------------

// File: rtl/koa_seq_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier: FSM state
// encoding, default operand width and partial-product width helpers.
package koa_seq_pkg;

  localparam int KOA_SW_DEFAULT = 54;
  localparam int KOA_H_DEFAULT  = KOA_SW_DEFAULT / 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_L = 3'd1,
    MUL_R = 3'd2,
    MUL_M = 3'd3,
    COMB  = 3'd4,
    DONE  = 3'd5
  } koa_state_e;

  // Width of the Q_L / Q_R partial products for half-width h.
  function automatic int koa_q_width(input int h);
    return 2 * h;
  endfunction

  // Width of the Q_M partial product; the half sums carry one extra bit each.
  function automatic int koa_qm_width(input int h);
    return 2 * h + 2;
  endfunction

endpackage

// File: rtl/koa_seq_core.sv
// Combinational unsigned W x W multiplier shared by all three Karatsuba
// partial products.
module koa_seq_core
  import koa_seq_pkg::*;
#(
  parameter int W = KOA_H_DEFAULT + 1
) (
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic [2*W-1:0] prod
);

  assign prod = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

endmodule

// File: rtl/koa_seq_ctrl.sv
// Sequential one-level Karatsuba multiplier: a single (H+1)-bit product unit
// is time-shared over Q_L, Q_R and Q_M, then the partials are combined.
module koa_seq_ctrl
  import koa_seq_pkg::*;
#(
  parameter int SW = KOA_SW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2*SW-1:0] sgf_result_o,
  output logic            busy_o
);

  localparam int H   = SW / 2;
  localparam int QW  = koa_q_width(H);
  localparam int QMW = koa_qm_width(H);

  koa_state_e state_r;
  koa_state_e next_state_s;

  logic [SW-1:0]   a_r;
  logic [SW-1:0]   b_r;
  logic [H:0]      suma_r;
  logic [H:0]      sumb_r;
  logic [QW-1:0]   ql_r;
  logic [QW-1:0]   qr_r;
  logic [QMW-1:0]  qm_r;
  logic [2*SW-1:0] result_r;

  logic [H:0]      mul_a_s;
  logic [H:0]      mul_b_s;
  logic [QMW-1:0]  prod_s;
  logic [QMW-1:0]  mid_s;
  logic [2*SW-1:0] comb_s;

  koa_seq_core #(
    .W (H + 1)
  ) u_core (
    .op_a (mul_a_s),
    .op_b (mul_b_s),
    .prod (prod_s)
  );

  // Middle term is never negative, so plain unsigned subtraction suffices.
  // Modular 2*SW-bit arithmetic gives the same low bits as a 2*SW+1-bit sum.
  assign mid_s  = qm_r - {2'b00, ql_r} - {2'b00, qr_r};
  assign comb_s = {ql_r, qr_r} + ({{(2*SW-QMW){1'b0}}, mid_s} << H);

  // Next-state decode and product-unit operand steering.
  always_comb begin
    next_state_s = state_r;
    mul_a_s      = '0;
    mul_b_s      = '0;
    case (state_r)
      IDLE: begin
        if (in_valid_i) begin
          next_state_s = MUL_L;
        end else begin
          next_state_s = IDLE;
        end
      end
      MUL_L: begin
        mul_a_s      = {1'b0, a_r[SW-1:H]};
        mul_b_s      = {1'b0, b_r[SW-1:H]};
        next_state_s = MUL_R;
      end
      MUL_R: begin
        mul_a_s      = {1'b0, a_r[H-1:0]};
        mul_b_s      = {1'b0, b_r[H-1:0]};
        next_state_s = MUL_M;
      end
      MUL_M: begin
        mul_a_s      = suma_r;
        mul_b_s      = sumb_r;
        next_state_s = COMB;
      end
      COMB: begin
        next_state_s = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture, partial-product and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      suma_r   <= '0;
      sumb_r   <= '0;
      ql_r     <= '0;
      qr_r     <= '0;
      qm_r     <= '0;
      result_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i) begin
            a_r    <= Data_A_i;
            b_r    <= Data_B_i;
            suma_r <= {1'b0, Data_A_i[SW-1:H]} + {1'b0, Data_A_i[H-1:0]};
            sumb_r <= {1'b0, Data_B_i[SW-1:H]} + {1'b0, Data_B_i[H-1:0]};
          end
        end
        MUL_L:   ql_r     <= prod_s[QW-1:0];
        MUL_R:   qr_r     <= prod_s[QW-1:0];
        MUL_M:   qm_r     <= prod_s;
        COMB:    result_r <= comb_s;
        default: ;
      endcase
    end
  end

  assign in_ready_o   = (state_r == IDLE);
  assign busy_o       = (state_r != IDLE);
  assign out_valid_o  = (state_r == DONE);
  assign sgf_result_o = result_r;

endmodule

// File: tb/tb_koa_seq_ctrl.sv
// Self-checking bench for koa_seq_ctrl: directed corner operands plus random
// operands, checked against a plain A*B reference with handshake timing.
module tb_koa_seq_ctrl;

  localparam int SW = 54;

  logic            clk;
  logic            rst;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [SW-1:0]   Data_A_i;
  logic [SW-1:0]   Data_B_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [2*SW-1:0] sgf_result_o;
  logic            busy_o;

  int n_tests;
  int n_fail;

  koa_seq_ctrl #(.SW(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .Data_A_i     (Data_A_i),
    .Data_B_i     (Data_B_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .sgf_result_o (sgf_result_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       r = '1;
      1:       r[26:0] = '1;
      2:       r[53:27] = '1;
      default: ;
    endcase
    return r[SW-1:0];
  endfunction

  // One full transaction: accept, 4-edge latency, optional DONE stall, drain.
  task automatic run_op(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input int stall, input bit noisy);
    logic [2*SW-1:0] exp_v;
    int n;
    exp_v = {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
    n = 0;
    while (!in_ready_o && n < 20) begin
      step();
      n++;
    end
    check_val("ready_before_accept", 128'(in_ready_o), 128'(1'b1));
    in_valid_i  = 1'b1;
    Data_A_i    = a;
    Data_B_i    = b;
    out_ready_i = 1'($urandom_range(0, 1));
    step();
    for (int k = 1; k <= 4; k++) begin
      if (noisy) begin
        in_valid_i = 1'b1;
        Data_A_i   = rnd_op();
        Data_B_i   = rnd_op();
      end else begin
        in_valid_i = 1'b0;
      end
      out_ready_i = 1'($urandom_range(0, 1));
      check_val("busy_in_flight", 128'(busy_o), 128'(1'b1));
      check_val("ready_in_flight", 128'(in_ready_o), 128'(1'b0));
      check_val("valid_early", 128'(out_valid_o), 128'(1'b0));
      step();
    end
    check_val("valid_at_t4", 128'(out_valid_o), 128'(1'b1));
    check_val("product", 128'(sgf_result_o), 128'(exp_v));
    for (int s = 0; s < stall; s++) begin
      out_ready_i = 1'b0;
      in_valid_i  = noisy;
      step();
      check_val("stall_valid", 128'(out_valid_o), 128'(1'b1));
      check_val("stall_ready", 128'(in_ready_o), 128'(1'b0));
      check_val("stall_result", 128'(sgf_result_o), 128'(exp_v));
    end
    out_ready_i = 1'b1;
    in_valid_i  = 1'b0;
    step();
    out_ready_i = 1'b0;
    check_val("drain_valid", 128'(out_valid_o), 128'(1'b0));
    check_val("drain_ready", 128'(in_ready_o), 128'(1'b1));
    check_val("drain_busy", 128'(busy_o), 128'(1'b0));
    check_val("result_retained", 128'(sgf_result_o), 128'(exp_v));
  endtask

  initial begin
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    Data_A_i    = '0;
    Data_B_i    = '0;
    step();
    step();
    rst = 1'b0;
    check_val("reset_ready", 128'(in_ready_o), 128'(1'b1));
    check_val("reset_valid", 128'(out_valid_o), 128'(1'b0));
    check_val("reset_busy", 128'(busy_o), 128'(1'b0));
    check_val("reset_result", 128'(sgf_result_o), 128'd0);

    run_op(54'd3, 54'd5, 0, 1'b0);
    run_op('1, '1, 0, 1'b0);
    run_op(54'd1 << 27, 54'd1 << 27, 0, 1'b0);
    run_op((54'd1 << 27) - 54'd1, (54'd1 << 27) + 54'd1, 0, 1'b0);
    run_op(rnd_op(), rnd_op(), 3, 1'b0);
    run_op(54'd123456789, 54'd987654321, 2, 1'b1);
    run_op('0, '1, 0, 1'b0);

    // Reset mid-operation (in MUL_M), with an offered operand on the same edge.
    in_valid_i = 1'b1;
    Data_A_i   = rnd_op();
    Data_B_i   = rnd_op();
    step();
    in_valid_i = 1'b0;
    step();
    step();
    rst        = 1'b1;
    in_valid_i = 1'b1;
    step();
    rst        = 1'b0;
    in_valid_i = 1'b0;
    check_val("midreset_ready", 128'(in_ready_o), 128'(1'b1));
    check_val("midreset_valid", 128'(out_valid_o), 128'(1'b0));
    check_val("midreset_busy", 128'(busy_o), 128'(1'b0));
    check_val("midreset_result", 128'(sgf_result_o), 128'd0);
    step();
    check_val("midreset_no_accept", 128'(busy_o), 128'(1'b0));
    run_op(54'd1000003, 54'd777, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      a = rnd_op();
      b = rnd_op();
      run_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
